decode_stage: RTL and testbench
===============================

# decode_stage

Parametrised MIPS instruction-decode stage with its ID/EX pipeline register. It decodes one instruction per cycle into a registered control/operand bundle for EX, reads the external register file, forwards results from EX/MEM, and interlocks load-use hazards via valid/ready handshakes. It sits between fetch and execute.

## Interface
- DATA_W, 32, datapath width; must be ≥32.
- FWD_EN, 1, 1 = EX/MEM forwarding; 0 = no forwarding, stall on every RAW dependency.
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-low reset.
- in_valid, in_ready  in/out  1  fetch handshake.
- in_inst  in  32  instruction word.
- rf_ra1, rf_ra2  out  5  register-file read addresses (rs, rt), combinational from in_inst.
- rf_rd1, rf_rd2  in  DATA_W  register-file read data, combinational.
- exf_we, exf_wa, exf_wd  in  1/5/DATA_W  result of the instruction currently in EX.
- memf_we, memf_wa, memf_wd  in  1/5/DATA_W  final write-back value of the instruction in MEM.
- flush  in  1  discard the incoming instruction and the ID/EX contents.
- out_valid, out_ready  out/in  1  EX handshake.
- out_alu_op  out  4  ALU operation code.
- out_opa, out_opb  out  DATA_W  ALU operands.
- out_st_data  out  DATA_W  forwarded rt value, used as store data.
- out_wa, out_we  out  5/1  destination register and write enable.
- out_mem_rd, out_mem_we  out  1  load/store.
- out_mem_len  out  2  0 = byte, 1 = half, 2 = word.
- out_illegal  out  1  unrecognised opcode/funct.

## Operation
- Supported instructions:
  - R-type (funct): ADDU, SUBU, AND, OR, XOR, NOR, SLT, SLL, SRL, SRA.
  - I-type: ADDIU, SLTI, ANDI, ORI, XORI, LUI, LB, LH, LW, SB, SH, SW.
  - Anything else: out_illegal=1, out_we=0, out_mem_we=0, out_mem_rd=0; the instruction still passes.
- Destination: rd for R-type, rt for I-type. out_we=0 for stores and whenever the destination is r0.
- Immediates:
  - Sign-extended to DATA_W for ADDIU, SLTI, loads and stores.
  - Zero-extended for ANDI, ORI, XORI.
  - LUI: imm<<16.
  - Shifts: out_opa = rt value, out_opb = zero-extended sa.
- Operand source priority: r0 always reads 0. Otherwise EX forward (exf_we && exf_wa match) over MEM forward over rf data. With FWD_EN=0, forwarding is not used.
- Source usage:
  - uses_rs for all except shifts and LUI.
  - uses_rt for R-type and stores.
- Hazard (combinational):
  - FWD_EN=1: out_valid && out_mem_rd && out_wa≠0 && a used source equals out_wa.
  - FWD_EN=0: any used nonzero source equals out_wa (out_valid && out_we) or memf_wa (memf_we).
- Register-load rules:
  - advance = !out_valid || out_ready.
  - in_ready = advance && !hazard, or flush.
  - On advance with in_valid && !hazard: the register loads the decoded bundle.
  - On advance with a hazard: the register loads a bubble (out_valid=0).
  - When !advance: hold all outputs.
- flush: next cycle out_valid=0. The incoming instruction is consumed and dropped. Flush overrides hazard and stall.

## Timing
- Latency: one cycle, in_valid&&in_ready at edge N gives out_valid at N+1.
- Throughput: 1 instruction/cycle without hazards.
- Load-use penalty: exactly one bubble with FWD_EN=1. With FWD_EN=0, stall until the producer leaves MEM.
- Reset (rst=0 at a clock edge): all out_* registers are 0, including out_valid. in_ready follows combinationally (1 after reset). Reset mid-stall discards the held instruction.
- Outputs are stable while out_valid && !out_ready.

## Structure
- Package pipe_pkg:
  - ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3, ALU_XOR=4, ALU_NOR=5, ALU_SLT=6, ALU_SLL=7, ALU_SRL=8, ALU_SRA=9, ALU_LUI=10.
  - Opcode/funct constants, MEM_B/MEM_H/MEM_W.
  - Decoded-control struct type.
- Sub-module decode_ctrl: purely combinational opcode/funct table producing alu_op, imm mode, uses_rs/rt, dest select, mem controls, illegal.
- decode_stage holds the forwarding muxes, hazard logic and the ID/EX register.

## Test plan
- Reset, then ADDIU r1,r0,-5 with rf zero → next cycle out_valid=1, opa=0, opb=0xFFFFFFFB, out_wa=1, alu_op=ADD.
- ORI r2,r0,0x8000 → opb=0x00008000. LUI r3,0x1234 → opb=0x12340000.
- ADDU r4,r1,r2 with exf_we=1/exf_wa=1/exf_wd=7 and memf_wa=1/memf_wd=9 → opa=7 (EX wins). rs=r0 with exf_wa=0 → opa=0.
- LW r5,0(r1) followed by ADDU r6,r5,r5, out_ready=1 → one bubble cycle with in_ready=0. The ADDU then issues with opa=opb=memf_wd. With FWD_EN=0 it stalls until memf clears.
- out_ready held low for 3 cycles with in_valid=1 → outputs hold, in_ready=0. Flush in cycle 2 → out_valid=0 next cycle.
- Opcode 0x3F → out_illegal=1, out_we=0, out_mem_we=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared decode definitions: ALU codes, MIPS opcode/funct values,
// memory access sizes and the decoded-control bundle.
package pipe_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_NOR = 4'd5;
  localparam logic [3:0] ALU_SLT = 4'd6;
  localparam logic [3:0] ALU_SLL = 4'd7;
  localparam logic [3:0] ALU_SRL = 4'd8;
  localparam logic [3:0] ALU_SRA = 4'd9;
  localparam logic [3:0] ALU_LUI = 4'd10;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;

  // How operand B is formed: rt value, or one of the immediate flavours.
  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_SEXT,
    IMM_ZEXT,
    IMM_LUI,
    IMM_SHAMT
  } imm_mode_t;

  typedef struct packed {
    logic [3:0] alu_op;
    imm_mode_t  imm_mode;
    logic       uses_rs;
    logic       uses_rt;
    logic       dest_rd;   // 1: rd is the destination, 0: rt
    logic       reg_we;    // writes a register (before the r0 check)
    logic       mem_rd;
    logic       mem_we;
    logic [1:0] mem_len;
    logic       illegal;
  } ctrl_t;

  // True when a nonzero register a is read by the decoded instruction.
  function automatic logic src_hit(input ctrl_t c, input logic [4:0] rs,
                                   input logic [4:0] rt, input logic [4:0] a);
    return (a != 5'd0) && ((c.uses_rs && (rs == a)) || (c.uses_rt && (rt == a)));
  endfunction

endpackage

// File: rtl/decode_ctrl.sv
// Combinational opcode/funct table for the supported MIPS subset.
module decode_ctrl
  import pipe_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ctrl_t      ctrl
);

  // Translate opcode/funct into the control bundle; unknown encodings
  // produce an inert, illegal-flagged bundle.
  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.uses_rs = 1'b1;
        ctrl.uses_rt = 1'b1;
        ctrl.dest_rd = 1'b1;
        ctrl.reg_we  = 1'b1;
        case (funct)
          FN_ADDU: ctrl.alu_op = ALU_ADD;
          FN_SUBU: ctrl.alu_op = ALU_SUB;
          FN_AND:  ctrl.alu_op = ALU_AND;
          FN_OR:   ctrl.alu_op = ALU_OR;
          FN_XOR:  ctrl.alu_op = ALU_XOR;
          FN_NOR:  ctrl.alu_op = ALU_NOR;
          FN_SLT:  ctrl.alu_op = ALU_SLT;
          FN_SLL, FN_SRL, FN_SRA: begin
            ctrl.alu_op   = (funct == FN_SLL) ? ALU_SLL :
                            (funct == FN_SRL) ? ALU_SRL : ALU_SRA;
            ctrl.imm_mode = IMM_SHAMT;
            ctrl.uses_rs  = 1'b0;
          end
          default: begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
          end
        endcase
      end
      OP_ADDIU, OP_SLTI: begin
        ctrl.alu_op   = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
        ctrl.imm_mode = IMM_SEXT;
        ctrl.uses_rs  = 1'b1;
        ctrl.reg_we   = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl.alu_op   = (opcode == OP_ANDI) ? ALU_AND :
                        (opcode == OP_ORI)  ? ALU_OR  : ALU_XOR;
        ctrl.imm_mode = IMM_ZEXT;
        ctrl.uses_rs  = 1'b1;
        ctrl.reg_we   = 1'b1;
      end
      OP_LUI: begin
        ctrl.alu_op   = ALU_LUI;
        ctrl.imm_mode = IMM_LUI;
        ctrl.reg_we   = 1'b1;
      end
      OP_LB, OP_LH, OP_LW: begin
        ctrl.alu_op   = ALU_ADD;
        ctrl.imm_mode = IMM_SEXT;
        ctrl.uses_rs  = 1'b1;
        ctrl.reg_we   = 1'b1;
        ctrl.mem_rd   = 1'b1;
        ctrl.mem_len  = (opcode == OP_LB) ? MEM_B : (opcode == OP_LH) ? MEM_H : MEM_W;
      end
      OP_SB, OP_SH, OP_SW: begin
        ctrl.alu_op   = ALU_ADD;
        ctrl.imm_mode = IMM_SEXT;
        ctrl.uses_rs  = 1'b1;
        ctrl.uses_rt  = 1'b1;
        ctrl.mem_we   = 1'b1;
        ctrl.mem_len  = (opcode == OP_SB) ? MEM_B : (opcode == OP_SH) ? MEM_H : MEM_W;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// MIPS decode stage: operand forwarding, load-use interlock and the
// ID/EX pipeline register feeding execute.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// in_ready may depend combinationally on in_inst and out_ready; outputs
// are held unchanged while out_valid && !out_ready.
module decode_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter bit FWD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  output logic [4:0]        rf_ra1,
  output logic [4:0]        rf_ra2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  input  logic              exf_we,
  input  logic [4:0]        exf_wa,
  input  logic [DATA_W-1:0] exf_wd,
  input  logic              memf_we,
  input  logic [4:0]        memf_wa,
  input  logic [DATA_W-1:0] memf_wd,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_alu_op,
  output logic [DATA_W-1:0] out_opa,
  output logic [DATA_W-1:0] out_opb,
  output logic [DATA_W-1:0] out_st_data,
  output logic [4:0]        out_wa,
  output logic              out_we,
  output logic              out_mem_rd,
  output logic              out_mem_we,
  output logic [1:0]        out_mem_len,
  output logic              out_illegal
);

  logic [5:0]        opcode, funct;
  logic [4:0]        rs, rt, rd, sa;
  logic [15:0]       imm;
  ctrl_t             ctrl;
  logic [DATA_W-1:0] rs_val, rt_val, opa_d, opb_d;
  logic [4:0]        wa_d;
  logic              we_d, hazard, advance;

  assign opcode = in_inst[31:26];
  assign rs     = in_inst[25:21];
  assign rt     = in_inst[20:16];
  assign rd     = in_inst[15:11];
  assign sa     = in_inst[10:6];
  assign funct  = in_inst[5:0];
  assign imm    = in_inst[15:0];

  assign rf_ra1 = rs;
  assign rf_ra2 = rt;

  decode_ctrl u_ctrl (
    .opcode (opcode),
    .funct  (funct),
    .ctrl   (ctrl)
  );

  // rs operand: r0 is hardwired zero, then EX result, then MEM result, then RF.
  always_comb begin
    rs_val = rf_rd1;
    if (rs == 5'd0)                                  rs_val = '0;
    else if (FWD_EN && exf_we && (exf_wa == rs))     rs_val = exf_wd;
    else if (FWD_EN && memf_we && (memf_wa == rs))   rs_val = memf_wd;
  end

  // rt operand with the same priority as rs.
  always_comb begin
    rt_val = rf_rd2;
    if (rt == 5'd0)                                  rt_val = '0;
    else if (FWD_EN && exf_we && (exf_wa == rt))     rt_val = exf_wd;
    else if (FWD_EN && memf_we && (memf_wa == rt))   rt_val = memf_wd;
  end

  // ALU operands: shifts take the rt value on A and the shift amount on B.
  always_comb begin
    opa_d = (ctrl.imm_mode == IMM_SHAMT) ? rt_val : rs_val;
    case (ctrl.imm_mode)
      IMM_SEXT:  opb_d = DATA_W'($signed(imm));
      IMM_ZEXT:  opb_d = DATA_W'(imm);
      IMM_LUI:   opb_d = DATA_W'({imm, 16'h0000});
      IMM_SHAMT: opb_d = DATA_W'(sa);
      default:   opb_d = rt_val;
    endcase
  end

  assign wa_d = ctrl.dest_rd ? rd : rt;
  assign we_d = ctrl.reg_we && (wa_d != 5'd0);

  // With forwarding only a load sitting in EX blocks its consumer; without
  // it any pending write in EX or MEM to a used source blocks.
  always_comb begin
    if (FWD_EN)
      hazard = out_valid && out_mem_rd && src_hit(ctrl, rs, rt, out_wa);
    else
      hazard = (out_valid && out_we && src_hit(ctrl, rs, rt, out_wa)) ||
               (memf_we && src_hit(ctrl, rs, rt, memf_wa));
  end

  assign advance  = !out_valid || out_ready;
  assign in_ready = (advance && !hazard) || flush;

  // ID/EX register: load a decoded instruction, insert a bubble, or hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      out_alu_op  <= ALU_ADD;
      out_opa     <= '0;
      out_opb     <= '0;
      out_st_data <= '0;
      out_wa      <= '0;
      out_we      <= 1'b0;
      out_mem_rd  <= 1'b0;
      out_mem_we  <= 1'b0;
      out_mem_len <= MEM_B;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (advance) begin
      if (in_valid && !hazard) begin
        out_valid   <= 1'b1;
        out_alu_op  <= ctrl.alu_op;
        out_opa     <= opa_d;
        out_opb     <= opb_d;
        out_st_data <= rt_val;
        out_wa      <= wa_d;
        out_we      <= we_d;
        out_mem_rd  <= ctrl.mem_rd;
        out_mem_we  <= ctrl.mem_we;
        out_mem_len <= ctrl.mem_len;
        out_illegal <= ctrl.illegal;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: table of single-instruction vectors plus
// hand-written load-use, hold/flush, reset-during-stall and no-forwarding
// sequences. Issued bundles are checked through an expected queue.
module tb_decode_stage;

  localparam int BW = 111;
  localparam logic [BW-1:0] FULL = {BW{1'b1}};
  // Illegal encodings leave alu_op and mem_len undefined.
  localparam logic [BW-1:0] ILL_MASK = {4'h0, {96{1'b1}}, 5'h1F, 3'b111, 2'b00, 1'b1};

  logic        clk, rst;
  logic        in_valid, in_valid1, in_ready, nf_in_ready;
  logic [31:0] in_inst, rf_rd1, rf_rd2, exf_wd, memf_wd;
  logic        exf_we, memf_we, flush, out_ready;
  logic [4:0]  exf_wa, memf_wa;
  logic [4:0]  rf_ra1, rf_ra2, nf_rf_ra1, nf_rf_ra2;
  logic        out_valid, out_we, out_mem_rd, out_mem_we, out_illegal;
  logic [3:0]  out_alu_op;
  logic [31:0] out_opa, out_opb, out_st_data;
  logic [4:0]  out_wa;
  logic [1:0]  out_mem_len;
  logic        nf_out_valid, nf_out_we, nf_out_mem_rd, nf_out_mem_we, nf_out_illegal;
  logic [3:0]  nf_out_alu_op;
  logic [31:0] nf_out_opa, nf_out_opb, nf_out_st_data;
  logic [4:0]  nf_out_wa;
  logic [1:0]  nf_out_mem_len;

  int total = 0;
  int bad   = 0;
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] mask_q[$];

  decode_stage #(.DATA_W(32), .FWD_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .exf_we(exf_we), .exf_wa(exf_wa), .exf_wd(exf_wd),
    .memf_we(memf_we), .memf_wa(memf_wa), .memf_wd(memf_wd), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_alu_op(out_alu_op),
    .out_opa(out_opa), .out_opb(out_opb), .out_st_data(out_st_data),
    .out_wa(out_wa), .out_we(out_we), .out_mem_rd(out_mem_rd), .out_mem_we(out_mem_we),
    .out_mem_len(out_mem_len), .out_illegal(out_illegal)
  );

  decode_stage #(.DATA_W(32), .FWD_EN(1'b0)) dut_nf (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(nf_in_ready), .in_inst(in_inst),
    .rf_ra1(nf_rf_ra1), .rf_ra2(nf_rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .exf_we(exf_we), .exf_wa(exf_wa), .exf_wd(exf_wd),
    .memf_we(memf_we), .memf_wa(memf_wa), .memf_wd(memf_wd), .flush(flush),
    .out_valid(nf_out_valid), .out_ready(out_ready), .out_alu_op(nf_out_alu_op),
    .out_opa(nf_out_opa), .out_opb(nf_out_opb), .out_st_data(nf_out_st_data),
    .out_wa(nf_out_wa), .out_we(nf_out_we), .out_mem_rd(nf_out_mem_rd),
    .out_mem_we(nf_out_mem_we), .out_mem_len(nf_out_mem_len), .out_illegal(nf_out_illegal)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0]   inst, rd1, rd2;
    logic          xwe;
    logic [4:0]    xwa;
    logic [31:0]   xwd;
    logic          mwe;
    logic [4:0]    mwa;
    logic [31:0]   mwd;
    logic [BW-1:0] exp, mask;
  } vec_t;

  vec_t tbl[14];

  function automatic logic [BW-1:0] bun(input logic [3:0] alu, input logic [31:0] a,
      input logic [31:0] b, input logic [31:0] st, input logic [4:0] wa,
      input logic we, input logic mrd, input logic mwe, input logic [1:0] len,
      input logic ill);
    return {alu, a, b, st, wa, we, mrd, mwe, len, ill};
  endfunction

  function automatic vec_t mkv(input logic [31:0] inst, input logic [31:0] rd1,
      input logic [31:0] rd2, input logic xwe, input logic [4:0] xwa, input logic [31:0] xwd,
      input logic mwe, input logic [4:0] mwa, input logic [31:0] mwd,
      input logic [BW-1:0] exp, input logic [BW-1:0] mask);
    vec_t v;
    v.inst = inst; v.rd1 = rd1; v.rd2 = rd2;
    v.xwe = xwe; v.xwa = xwa; v.xwd = xwd;
    v.mwe = mwe; v.mwa = mwa; v.mwd = mwd;
    v.exp = exp; v.mask = mask;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [BW-1:0] e, input logic [BW-1:0] m);
    exp_q.push_back(e);
    mask_q.push_back(m);
  endtask

  task automatic set_fwd(input logic xwe, input logic [4:0] xwa, input logic [31:0] xwd,
      input logic mwe, input logic [4:0] mwa, input logic [31:0] mwd);
    exf_we = xwe; exf_wa = xwa; exf_wd = xwd;
    memf_we = mwe; memf_wa = mwa; memf_wd = mwd;
  endtask

  // Scoreboard: compare each newly issued bundle against the queue head.
  // Inputs change only at negedge+1, so out_ready seen here is the value
  // that governed the edge just passed.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    logic [BW-1:0] act, e, m;
    if (out_valid && !(prev_valid && !out_ready)) begin
      act = {out_alu_op, out_opa, out_opb, out_st_data, out_wa, out_we,
             out_mem_rd, out_mem_we, out_mem_len, out_illegal};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got %h want nothing", act);
      end else begin
        e = exp_q.pop_front();
        m = mask_q.pop_front();
        if (((act ^ e) & m) != '0) begin
          bad++;
          $display("FAIL sb_bundle: got %h want %h", act & m, e & m);
        end
      end
    end
    prev_valid = out_valid;
  end

  initial begin
    // inst, rd1, rd2, exf{we,wa,wd}, memf{we,wa,wd}, expected bundle, mask
    tbl[0]  = mkv(32'h2401FFFB, '0, '0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0,
                  bun(4'd0, 32'h0, 32'hFFFFFFFB, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0), FULL);
    tbl[1]  = mkv(32'h34028000, '0, '0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0,
                  bun(4'd3, 32'h0, 32'h00008000, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0), FULL);
    tbl[2]  = mkv(32'h3C031234, '0, '0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0,
                  bun(4'd10, 32'h0, 32'h12340000, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0), FULL);
    tbl[3]  = mkv(32'h00222021, 32'h11111111, 32'h22222222, 1'b1, 5'd1, 32'd7, 1'b1, 5'd1, 32'd9,
                  bun(4'd0, 32'd7, 32'h22222222, 32'h22222222, 5'd4, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0), FULL);
    tbl[4]  = mkv(32'h00022021, 32'h11111111, 32'h22222222, 1'b1, 5'd0, 32'h55, 1'b1, 5'd2, 32'h99,
                  bun(4'd0, 32'h0, 32'h99, 32'h99, 5'd4, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0), FULL);
    tbl[5]  = mkv(32'h00643823, 32'h10, 32'h3, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0,
                  bun(4'd1, 32'h10, 32'h3, 32'h3, 5'd7, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0), FULL);
    tbl[6]  = mkv(32'h00094103, 32'h0, 32'h80000000, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0,
                  bun(4'd9, 32'h80000000, 32'd4, 32'h80000000, 5'd8, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0), FULL);
    tbl[7]  = mkv(32'hAD6AFFFC, 32'h1000, 32'hCAFE, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0,
                  bun(4'd0, 32'h1000, 32'hFFFFFFFC, 32'hCAFE, 5'd10, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0), FULL);
    tbl[8]  = mkv(32'h81AC0003, 32'h2000, 32'h77, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0,
                  bun(4'd0, 32'h2000, 32'd3, 32'h77, 5'd12, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0), FULL);
    tbl[9]  = mkv(32'h84200002, 32'd5, 32'h0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0,
                  bun(4'd0, 32'd5, 32'd2, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0), FULL);
    tbl[10] = mkv(32'hFC000000, '0, '0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0,
                  bun(4'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1), ILL_MASK);
    tbl[11] = mkv(32'h0000003F, '0, '0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0,
                  bun(4'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1), ILL_MASK);
    tbl[12] = mkv(32'h01F0702A, 32'hFFFFFFFF, 32'd1, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0,
                  bun(4'd6, 32'hFFFFFFFF, 32'd1, 32'd1, 5'd14, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0), FULL);
    tbl[13] = mkv(32'h3251FFFF, 32'hABCD, 32'h0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0,
                  bun(4'd2, 32'hABCD, 32'h0000FFFF, 32'h0, 5'd17, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0), FULL);

    // Reset
    rst = 1'b0; in_valid = 1'b0; in_valid1 = 1'b0; in_inst = '0;
    rf_rd1 = '0; rf_rd2 = '0; flush = 1'b0; out_ready = 1'b1;
    set_fwd(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    repeat (3) @(posedge clk);
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_bundle_zero", 32'({out_alu_op, out_opa, out_opb, out_st_data, out_wa, out_we,
        out_mem_rd, out_mem_we, out_mem_len, out_illegal} != '0), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b1;

    // Table of independent instructions, one per cycle
    for (int i = 0; i < 14; i++) begin
      step();
      in_valid = 1'b1; in_inst = tbl[i].inst; rf_rd1 = tbl[i].rd1; rf_rd2 = tbl[i].rd2;
      set_fwd(tbl[i].xwe, tbl[i].xwa, tbl[i].xwd, tbl[i].mwe, tbl[i].mwa, tbl[i].mwd);
      #1;
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
      if (in_ready) push(tbl[i].exp, tbl[i].mask);
    end
    step();
    in_valid = 1'b0; set_fwd(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    step();

    // Load-use: LW r5,0(r1) then ADDU r6,r5,r5 -> one bubble, then MEM forward
    in_valid = 1'b1; in_inst = 32'h8C250000; rf_rd1 = 32'h100; rf_rd2 = '0;
    #1;
    chk("lu_lw_in_ready", 32'(in_ready), 32'd1);
    push(bun(4'd0, 32'h100, 32'h0, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0), FULL);
    step();
    in_inst = 32'h00A53021;
    #1;
    chk("lu_stall_in_ready", 32'(in_ready), 32'd0);
    step();
    set_fwd(1'b0, 5'd0, '0, 1'b1, 5'd5, 32'hBEEF);
    rf_rd1 = 32'h1234; rf_rd2 = 32'h1234;
    #1;
    chk("lu_bubble_valid", 32'(out_valid), 32'd0);
    chk("lu_resume_in_ready", 32'(in_ready), 32'd1);
    push(bun(4'd0, 32'hBEEF, 32'hBEEF, 32'hBEEF, 5'd6, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0), FULL);
    step();
    in_valid = 1'b0; set_fwd(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    step();

    // Hold under backpressure, then flush while stalled
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h34140055; rf_rd1 = '0; rf_rd2 = '0;
    #1;
    chk("hold_accept_in_ready", 32'(in_ready), 32'd1);
    push(bun(4'd3, 32'h0, 32'h55, 32'h0, 5'd20, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0), FULL);
    step();
    in_inst = 32'h38150001;
    #1;
    chk("hold_in_ready", 32'(in_ready), 32'd0);
    chk("hold_c1_opb", out_opb, 32'h55);
    step();
    chk("hold_c2_valid", 32'(out_valid), 32'd1);
    chk("hold_c2_wa", 32'(out_wa), 32'd20);
    chk("hold_c2_opb", out_opb, 32'h55);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'd0);
    step();
    chk("flush_dropped", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    step();

    // Reset while stalled discards the held instruction
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h34140055;
    #1;
    chk("rs_accept_in_ready", 32'(in_ready), 32'd1);
    push(bun(4'd3, 32'h0, 32'h55, 32'h0, 5'd20, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0), FULL);
    step();
    in_inst = 32'h38150001;
    rst = 1'b0;
    step();
    rst = 1'b1; in_valid = 1'b0;
    #1;
    chk("rs_valid", 32'(out_valid), 32'd0);
    chk("rs_in_ready", 32'(in_ready), 32'd1);
    step();
    chk("rs_stays_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    step();

    // No-forwarding instance: stall until the load leaves MEM, read RF only
    in_valid1 = 1'b1; in_inst = 32'h8C250000; rf_rd1 = 32'h100; rf_rd2 = '0;
    #1;
    chk("nf_lw_in_ready", 32'(nf_in_ready), 32'd1);
    step();
    in_inst = 32'h00A53021;
    #1;
    chk("nf_ex_stall", 32'(nf_in_ready), 32'd0);
    chk("nf_lw_wa", 32'(nf_out_wa), 32'd5);
    step();
    set_fwd(1'b1, 5'd5, 32'hDEAD, 1'b1, 5'd5, 32'hBEEF);
    rf_rd1 = 32'h1234; rf_rd2 = 32'h1234;
    #1;
    chk("nf_mem_stall", 32'(nf_in_ready), 32'd0);
    chk("nf_bubble", 32'(nf_out_valid), 32'd0);
    step();
    set_fwd(1'b1, 5'd5, 32'hDEAD, 1'b0, 5'd0, '0);
    rf_rd1 = 32'h4321; rf_rd2 = 32'h4321;
    #1;
    chk("nf_resume", 32'(nf_in_ready), 32'd1);
    step();
    in_valid1 = 1'b0; set_fwd(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    chk("nf_valid", 32'(nf_out_valid), 32'd1);
    chk("nf_opa_rf", nf_out_opa, 32'h4321);
    chk("nf_opb_rf", nf_out_opb, 32'h4321);
    chk("nf_wa", 32'(nf_out_wa), 32'd6);

    // Final report
    step();
    step();
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
